// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial bit-pattern generator.
// Latches pattern/length/repeat/gap on start and emits the pattern MSB-first,
// one bit per clock, with optional idle gap bits between frames.
//
// Handshake: start is sampled only in IDLE (abort wins if both are high).
// busy is high from the cycle after an accepted start until the last frame
// bit; done pulses for one cycle after the final frame. abort in any
// non-IDLE state returns to IDLE with all outputs cleared and no done pulse.
module seq_pattern_gen #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             gap_bit,
    output logic             dout,
    output logic             dout_valid,
    output logic             frame_start,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state_o
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic             gap_bit_q, gap_bit_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic             dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             fs_q, fs_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign dout        = dout_q;
    assign dout_valid  = valid_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

    // Next-state and counter logic; outputs are derived from the next state so
    // they can be registered and still appear in the cycle after the decision.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        len_d     = len_q;
        gap_len_d = gap_len_q;
        gap_bit_d = gap_bit_q;
        frames_d  = frames_q;
        bit_idx_d = bit_idx_q;
        gap_cnt_d = gap_cnt_q;
        fs_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    pat_d     = pattern;
                    len_d     = pat_len;
                    gap_len_d = gap_len;
                    gap_bit_d = gap_bit;
                    if (pat_len == '0 || pat_len > LEN_W'(PAT_W) || repeat_cnt == '0) begin
                        // Degenerate request: report completion without sending.
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_SHIFT;
                        bit_idx_d = IDX_W'(pat_len - LEN_W'(1));
                        frames_d  = repeat_cnt;
                        fs_d      = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                if (bit_idx_q == '0) begin
                    frames_d = frames_q - CNT_W'(1);
                    if (frames_d != '0) begin
                        if (gap_len_q != '0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = gap_len_q;
                        end else begin
                            // Back-to-back frame: reload without a bubble.
                            bit_idx_d = IDX_W'(len_q - LEN_W'(1));
                            fs_d      = 1'b1;
                        end
                    end else begin
                        // No gap after the final frame.
                        state_d = S_DONE;
                    end
                end else begin
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(1)) begin
                    state_d   = S_SHIFT;
                    gap_cnt_d = '0;
                    bit_idx_d = IDX_W'(len_q - LEN_W'(1));
                    fs_d      = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort drops any run in progress back to a reset-like IDLE.
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            frames_d  = '0;
            bit_idx_d = '0;
            gap_cnt_d = '0;
            fs_d      = 1'b0;
        end

        dout_d = 1'b0;
        case (state_d)
            S_SHIFT: dout_d = pat_d[bit_idx_d];
            S_GAP:   dout_d = gap_bit_d;
            default: dout_d = 1'b0;
        endcase
        valid_d = (state_d == S_SHIFT);
        busy_d  = (state_d == S_SHIFT) || (state_d == S_GAP);
        done_d  = (state_d == S_DONE);
    end

    // State, shadow, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            gap_len_q <= '0;
            gap_bit_q <= 1'b0;
            frames_q  <= '0;
            bit_idx_q <= '0;
            gap_cnt_q <= '0;
            dout_q    <= 1'b0;
            valid_q   <= 1'b0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            gap_len_q <= gap_len_d;
            gap_bit_q <= gap_bit_d;
            frames_q  <= frames_d;
            bit_idx_q <= bit_idx_d;
            gap_cnt_q <= gap_cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            fs_q      <= fs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen. Expected waveforms are written as bit
// strings, leftmost bit = cycle 1 after the start edge.
module tb_seq_pattern_gen;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic [7:0] repeat_cnt;
    logic [3:0] gap_len;
    logic       gap_bit;
    logic       dout;
    logic       dout_valid;
    logic       frame_start;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state_o;

    int total;
    int bad;

    logic [31:0] got_v [5];
    logic [31:0] exp_v [5];
    string       sig_nm [5] = '{"dout", "dout_valid", "frame_start", "busy", "done"};

    seq_pattern_gen dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .pattern     (pattern),
        .pat_len     (pat_len),
        .repeat_cnt  (repeat_cnt),
        .gap_len     (gap_len),
        .gap_bit     (gap_bit),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state_o)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the run configuration and raise start for the next edge (cycle 0).
    task automatic arm(input logic [7:0] p, input logic [3:0] l, input logic [7:0] r,
                       input logic [3:0] g, input logic gb);
        pattern    = p;
        pat_len    = l;
        repeat_cnt = r;
        gap_len    = g;
        gap_bit    = gb;
        start      = 1'b1;
    endtask

    // Record n cycles of outputs; optionally poke start/abort/reset during a cycle.
    task automatic capture(input int n, input int restart_cyc, input int abort_cyc,
                           input int rst_cyc);
        for (int k = 0; k < 5; k++) got_v[k] = '0;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            got_v[0] = {got_v[0][30:0], dout};
            got_v[1] = {got_v[1][30:0], dout_valid};
            got_v[2] = {got_v[2][30:0], frame_start};
            got_v[3] = {got_v[3][30:0], busy};
            got_v[4] = {got_v[4][30:0], done};
            start = 1'b0;
            abort = 1'b0;
            reset = 1'b1;
            if (i == restart_cyc) begin
                start      = 1'b1;
                pattern    = 8'hF0;
                pat_len    = 4'd8;
                repeat_cnt = 8'd2;
                gap_len    = 4'd0;
                gap_bit    = 1'b1;
            end
            if (i == abort_cyc) abort = 1'b1;
            if (i == rst_cyc)   reset = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (dout !== 1'b0)        begin bad++; $display("FAIL reset dout: got=%b exp=0", dout); end
        total++; if (dout_valid !== 1'b0)  begin bad++; $display("FAIL reset dout_valid: got=%b exp=0", dout_valid); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset frame_start: got=%b exp=0", frame_start); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset busy: got=%b exp=0", busy); end
        total++; if (done !== 1'b0)        begin bad++; $display("FAIL reset done: got=%b exp=0", done); end
        total++; if (dbg_state_o !== 2'd0) begin bad++; $display("FAIL reset state: got=%0d exp=0", dbg_state_o); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        arm(8'h0D, 4'd4, 8'd1, 4'd0, 1'b0);
        capture(6, 0, 0, 0);
        exp_v = '{32'b110100, 32'b111100, 32'b100000, 32'b111100, 32'b000010};
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_v[k] !== exp_v[k]) begin
                bad++; $display("FAIL single %s: got=%b exp=%b", sig_nm[k], got_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_gap;
        arm(8'h0D, 4'd4, 8'd3, 4'd2, 1'b0);
        capture(18, 0, 0, 0);
        exp_v = '{32'b110100110100110100, 32'b111100111100111100, 32'b100000100000100000,
                  32'b111111111111111100, 32'b000000000000000010};
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_v[k] !== exp_v[k]) begin
                bad++; $display("FAIL gap %s: got=%b exp=%b", sig_nm[k], got_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_gap_bit;
        arm(8'h05, 4'd3, 8'd2, 4'd1, 1'b1);
        capture(9, 0, 0, 0);
        exp_v = '{32'b101110100, 32'b111011100, 32'b100010000, 32'b111111100, 32'b000000010};
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_v[k] !== exp_v[k]) begin
                bad++; $display("FAIL gap_bit %s: got=%b exp=%b", sig_nm[k], got_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        arm(8'h0D, 4'd4, 8'd2, 4'd0, 1'b1);
        capture(10, 0, 0, 0);
        exp_v = '{32'b1101110100, 32'b1111111100, 32'b1000100000, 32'b1111111100, 32'b0000000010};
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_v[k] !== exp_v[k]) begin
                bad++; $display("FAIL back_to_back %s: got=%b exp=%b", sig_nm[k], got_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_full_width;
        arm(8'hA5, 4'd8, 8'd1, 4'd3, 1'b1);
        capture(10, 0, 0, 0);
        exp_v = '{32'b1010010100, 32'b1111111100, 32'b1000000000, 32'b1111111100, 32'b0000000010};
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_v[k] !== exp_v[k]) begin
                bad++; $display("FAIL full_width %s: got=%b exp=%b", sig_nm[k], got_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_degenerate;
        logic [3:0] lens [3] = '{4'd0, 4'd4, 4'd9};
        logic [7:0] reps [3] = '{8'd1, 8'd0, 8'd1};
        for (int c = 0; c < 3; c++) begin
            arm(8'h0D, lens[c], reps[c], 4'd2, 1'b1);
            capture(3, 0, 0, 0);
            exp_v = '{32'b000, 32'b000, 32'b000, 32'b000, 32'b100};
            for (int k = 0; k < 5; k++) begin
                total++;
                if (got_v[k] !== exp_v[k]) begin
                    bad++; $display("FAIL degenerate%0d %s: got=%b exp=%b", c, sig_nm[k], got_v[k], exp_v[k]);
                end
            end
        end
    endtask

    task automatic test_restart_ignored;
        arm(8'h0D, 4'd4, 8'd1, 4'd0, 1'b0);
        capture(6, 2, 0, 0);
        exp_v = '{32'b110100, 32'b111100, 32'b100000, 32'b111100, 32'b000010};
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_v[k] !== exp_v[k]) begin
                bad++; $display("FAIL restart %s: got=%b exp=%b", sig_nm[k], got_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_mid_reset;
        arm(8'h0D, 4'd4, 8'd3, 4'd2, 1'b0);
        capture(6, 0, 0, 3);
        exp_v = '{32'b110000, 32'b111000, 32'b100000, 32'b111000, 32'b000000};
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_v[k] !== exp_v[k]) begin
                bad++; $display("FAIL mid_reset %s: got=%b exp=%b", sig_nm[k], got_v[k], exp_v[k]);
            end
        end
        arm(8'h0D, 4'd4, 8'd2, 4'd0, 1'b0);
        capture(10, 0, 0, 0);
        exp_v = '{32'b1101110100, 32'b1111111100, 32'b1000100000, 32'b1111111100, 32'b0000000010};
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_v[k] !== exp_v[k]) begin
                bad++; $display("FAIL after_reset %s: got=%b exp=%b", sig_nm[k], got_v[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_abort;
        arm(8'h0D, 4'd4, 8'd3, 4'd2, 1'b0);
        capture(9, 0, 6, 0);
        exp_v = '{32'b110100000, 32'b111100000, 32'b100000000, 32'b111111000, 32'b000000000};
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_v[k] !== exp_v[k]) begin
                bad++; $display("FAIL abort %s: got=%b exp=%b", sig_nm[k], got_v[k], exp_v[k]);
            end
        end
        arm(8'h0D, 4'd4, 8'd1, 4'd0, 1'b0);
        capture(6, 0, 0, 0);
        exp_v = '{32'b110100, 32'b111100, 32'b100000, 32'b111100, 32'b000010};
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_v[k] !== exp_v[k]) begin
                bad++; $display("FAIL after_abort %s: got=%b exp=%b", sig_nm[k], got_v[k], exp_v[k]);
            end
        end
        // abort together with start in IDLE: nothing happens.
        arm(8'h0D, 4'd4, 8'd1, 4'd0, 1'b0);
        abort = 1'b1;
        capture(3, 0, 0, 0);
        exp_v = '{32'b000, 32'b000, 32'b000, 32'b000, 32'b000};
        for (int k = 0; k < 5; k++) begin
            total++;
            if (got_v[k] !== exp_v[k]) begin
                bad++; $display("FAIL abort_idle %s: got=%b exp=%b", sig_nm[k], got_v[k], exp_v[k]);
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        pattern    = '0;
        pat_len    = '0;
        repeat_cnt = '0;
        gap_len    = '0;
        gap_bit    = 1'b0;
        test_reset;
        test_single;
        test_gap;
        test_gap_bit;
        test_back_to_back;
        test_full_width;
        test_degenerate;
        test_restart_ignored;
        test_mid_reset;
        test_abort;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
